mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word RAM behind a req/ack handshake with WAIT_CYCLES wait states.
// A request captured in IDLE completes with a one-cycle ack on the cycle after RESP.
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  cap_we;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem [DEPTH];
  logic                  fault;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  ram_wr;

  // Any set bit above the word range faults, so indexing never aliases
  assign fault    = (cap_addr[1:0] != 2'b00) || (cap_addr[31:DEPTH_LOG2+2] != '0);
  assign word_idx = cap_addr[DEPTH_LOG2+1:2];
  assign ram_wr   = (state == RESP) && cap_we && !fault && !reset;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (ram_wr)
      mem[word_idx] <= cap_wdata;
  end

  // Results are registered on the edge that ends RESP, so reset in RESP aborts cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              count <= 4'd0;
            end else begin
              state <= WAIT;
              count <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count <= 4'd1)
            state <= RESP;
        end
        RESP: begin
          ack   <= 1'b1;
          err   <= fault;
          state <= IDLE;
          if (!cap_we)
            rdata <= fault ? 32'd0 : mem[word_idx];
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with two wait states, one with none,
// checked against a word-array reference model plus fixed vectors and corner sequences.
module tb_mem_responder;

  localparam int WA    = 2;
  localparam int WB    = 0;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, err_a, busy_a;
  logic        ack_b, err_b, busy_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m  [2];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input int inst, output logic a, output logic e, output logic b,
                        output logic [31:0] r);
    if (inst == 0) begin
      a = ack_a; e = err_a; b = busy_a; r = rdata_a;
    end else begin
      a = ack_b; e = err_b; b = busy_b; r = rdata_b;
    end
  endtask

  // Reference: fault rule, RAM array and the last load result, independent of cycle timing
  function automatic void model_access(input int inst, input bit w, input logic [31:0] a,
                                       input logic [31:0] d, output logic e,
                                       output logic [31:0] rd);
    e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    if (w) begin
      if (!e) mem_m[inst][a[7:2]] = d;
    end else begin
      rd_m[inst] = e ? 32'd0 : mem_m[inst][a[7:2]];
    end
    rd = rd_m[inst];
  endfunction

  // One access at minimum spacing; lat_ok covers ack timing, busy and err outside the ack cycle
  task automatic applyStimulus(input int inst, input bit w, input logic [31:0] a_in,
                               input logic [31:0] d_in, input bit noise, output bit lat_ok,
                               output logic e_out, output logic [31:0] rd_out);
    int wc;
    logic a_s, e_s, b_s;
    logic [31:0] r_s;
    wc = (inst == 0) ? WA : WB;
    e_out = 1'bx;
    rd_out = 'x;
    @(negedge clk);
    we = w; addr = a_in; wdata = d_in;
    if (inst == 0) req_a = 1'b1; else req_b = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      addr = a_in ^ 32'h40; we = ~w; wdata = ~d_in;
    end else begin
      req_a = 1'b0; req_b = 1'b0;
    end
    sample(inst, a_s, e_s, b_s, r_s);
    lat_ok = (a_s === 1'b0) && (b_s === 1'b1) && (e_s === 1'b0);
    for (int k = 1; k <= wc + 1; k++) begin
      @(posedge clk); #1;
      sample(inst, a_s, e_s, b_s, r_s);
      if (k == wc + 1) begin
        lat_ok = lat_ok && (a_s === 1'b1) && (b_s === 1'b0);
        e_out  = e_s;
        rd_out = r_s;
        req_a  = 1'b0;
        req_b  = 1'b0;
      end else begin
        lat_ok = lat_ok && (a_s === 1'b0) && (b_s === 1'b1) && (e_s === 1'b0);
      end
    end
  endtask

  task automatic access_check(input string name, input int inst, input bit w,
                              input logic [31:0] a, input logic [31:0] d, input bit noise);
    logic exp_e, e;
    logic [31:0] exp_rd, rd;
    bit lat_ok;
    model_access(inst, w, a, d, exp_e, exp_rd);
    applyStimulus(inst, w, a, d, noise, lat_ok, e, rd);
    checkOutput({name, "_latency"}, {31'd0, lat_ok}, 32'd1);
    checkOutput({name, "_err"}, {31'd0, e}, {31'd0, exp_e});
    checkOutput({name, "_rdata"}, rd, exp_rd);
  endtask

  function automatic logic [31:0] gen_addr(input logic [31:0] last);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return last;
    if (r <= 6) return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if (r == 7) return {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
    return 32'h100 + $urandom_range(0, 32'h7FFF_FFFF);
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] last_a;
    logic [15:0] obs, expv;
    int extra;
    logic e_d;
    logic [31:0] rd_d;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rd_m[0] = 32'd0; rd_m[1] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack_a", {31'd0, ack_a}, 32'd0);
    checkOutput("reset_err_a", {31'd0, err_a}, 32'd0);
    checkOutput("reset_busy_a", {31'd0, busy_a}, 32'd0);
    checkOutput("reset_rdata_a", rdata_a, 32'd0);
    checkOutput("reset_ack_b", {31'd0, ack_b}, 32'd0);
    checkOutput("reset_busy_b", {31'd0, busy_b}, 32'd0);
    checkOutput("reset_rdata_b", rdata_b, 32'd0);

    // req coinciding with reset must be dropped; next edge is the first with reset low
    @(negedge clk);
    req_a = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h1;
    @(posedge clk); #1;
    checkOutput("reset_priority_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("reset_priority_ack", {31'd0, ack_a}, 32'd0);
    reset = 1'b0; req_a = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      access_check($sformatf("fill_a%0d", i), 0, 1'b1, 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      access_check($sformatf("fill_b%0d", i), 1, 1'b1, 32'(i * 4), $urandom, 1'b0);

    tbl[0] = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[2] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
    tbl[4] = '{1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0000_0000};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0001};
    tbl[6] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
    tbl[8] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    for (int i = 0; i < 10; i++) begin
      bit lat_ok;
      logic e;
      logic [31:0] rd;
      model_access(0, tbl[i].w, tbl[i].a, tbl[i].d, e_d, rd_d);
      applyStimulus(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, lat_ok, e, rd);
      checkOutput($sformatf("vec%0d_latency", i), {31'd0, lat_ok}, 32'd1);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
      checkOutput($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // req toggling during WAIT/RESP with another address must neither retarget nor queue
    access_check("busy_ignore", 0, 1'b0, 32'h10, 32'h0, 1'b1);
    extra = 0;
    for (int k = 0; k < WA + 3; k++) begin
      @(posedge clk); #1;
      if (ack_a === 1'b1 || busy_a === 1'b1) extra++;
    end
    checkOutput("busy_ignore_no_second_ack", 32'(extra), 32'd0);
    access_check("busy_ignore_untouched", 0, 1'b0, 32'h50, 32'h0, 1'b0);

    // req held high: acks recur every WA+2 cycles
    @(negedge clk);
    req_a = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    obs = '0; expv = '0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      obs[k] = ack_a;
      if (k <= 11 && k >= WA + 1 && ((k - (WA + 1)) % (WA + 2)) == 0) expv[k] = 1'b1;
      if (k == 11) req_a = 1'b0;
    end
    checkOutput("held_req_ack_pattern", {16'd0, obs}, {16'd0, expv});
    model_access(0, 1'b0, 32'h10, 32'h0, e_d, rd_d);
    checkOutput("held_req_rdata", rdata_a, rd_d);

    // reset landing on the RESP cycle aborts the store
    @(negedge clk);
    req_a = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_a = 1'b0;
    repeat (WA) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ack", {31'd0, ack_a}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("abort_rdata", rdata_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_m[0] = 32'd0; rd_m[1] = 32'd0;
    @(posedge clk); #1;
    checkOutput("abort_no_late_ack", {31'd0, ack_a}, 32'd0);
    access_check("abort_load", 0, 1'b0, 32'h20, 32'h0, 1'b0);

    last_a = 32'h0;
    for (int i = 0; i < 40; i++) begin
      last_a = gen_addr(last_a);
      access_check($sformatf("rand_a%0d", i), 0, 1'($urandom), last_a, $urandom, 1'b0);
    end

    access_check("zw_load4", 1, 1'b0, 32'h4, 32'h0, 1'b0);
    access_check("zw_store_fc", 1, 1'b1, 32'hFC, 32'h0BAD_CAFE, 1'b0);
    access_check("zw_load_fc", 1, 1'b0, 32'hFC, 32'h0, 1'b0);
    access_check("zw_store_oob", 1, 1'b1, 32'h100, 32'h7777_7777, 1'b0);
    access_check("zw_load_mis", 1, 1'b0, 32'h101, 32'h0, 1'b0);
    access_check("zw_load0", 1, 1'b0, 32'h0, 32'h0, 1'b0);
    last_a = 32'h0;
    for (int i = 0; i < 20; i++) begin
      last_a = gen_addr(last_a);
      access_check($sformatf("rand_b%0d", i), 1, 1'($urandom), last_a, $urandom, 1'b0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
